// File: rtl/lane_permute_pkg.sv
// Shared definitions for the lane permutation engine and its map block.
// Holds grid constants, the FSM state encoding and the lane routing function.
// Pure declarations: no latency, no flow control.
package lane_permute_pkg;

  localparam int GRID  = 5;
  localparam int LANES = GRID * GRID;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Flat index of the lane that lane (a,b) lands on under the forward map.
  function automatic int dest_idx(input int a, input int b);
    return ((3 * a + 2 * b + 2) % GRID) * GRID + a;
  endfunction

endpackage

// File: rtl/lane_permute_map.sv
// One application of the pi-style lane permutation (forward or inverse).
// Latency: purely combinational.
// Backpressure: none; pure wiring plus a 2:1 select.
module lane_permute_map
  import lane_permute_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [LANES*W-1:0] state_in,
  input  logic               mode,
  output logic [LANES*W-1:0] state_out
);

  logic [LANES*W-1:0] fwd;
  logic [LANES*W-1:0] inv;

  // Forward scatters lane (a,b) to its destination; inverse gathers from it.
  // The map is a bijection, so each half drives every lane exactly once.
  for (genvar a = 0; a < GRID; a++) begin : g_row
    for (genvar b = 0; b < GRID; b++) begin : g_col
      localparam int SRC = a * GRID + b;
      localparam int DST = dest_idx(a, b);
      assign fwd[DST*W +: W] = state_in[SRC*W +: W];
      assign inv[SRC*W +: W] = state_in[DST*W +: W];
    end
  end

  assign state_out = mode ? inv : fwd;

endmodule

// File: rtl/lane_permute_engine.sv
// Multi-round lane permutation engine: loads a 25-lane state, permutes it R times.
// Latency: R+1 cycles from accept to out_valid (1 cycle when R=0).
// Backpressure: result held in DONE until out_ready; no new job accepted until drained.
module lane_permute_engine
  import lane_permute_pkg::*;
#(
  parameter int W          = 1,
  parameter int MAX_ROUNDS = 24,
  parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*W-1:0]  in_data,
  input  logic [RW-1:0]       in_rounds,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*W-1:0]  out_data,
  output logic                busy
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

  fsm_e               fsm_q, fsm_d;
  logic [LANES*W-1:0] state_q, state_d;
  logic [RW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;

  logic               accept;
  logic [RW-1:0]      rounds_clamped;
  logic [LANES*W-1:0] mapped;

  assign accept         = in_valid && in_ready;
  assign rounds_clamped = (in_rounds > MAX_R) ? MAX_R : in_rounds;

  lane_permute_map #(.W(W)) u_map (
    .state_in  (state_q),
    .mode      (mode_q),
    .state_out (mapped)
  );

  // Next-state logic: load on accept, permute once per RUN cycle, drain in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = in_data;
          cnt_d   = rounds_clamped;
          mode_d  = in_mode;
          fsm_d   = (rounds_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        state_d = mapped;
        cnt_d   = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight job.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = state_q;

endmodule

// File: tb/tb_lane_permute_engine.sv
// Directed bench for lane_permute_engine at lane widths 1, 8 and 4.
// One shared stimulus bus drives three instances; sel picks the active one.
// Expected values are hand-derived lane positions or the original input data.
module tb_lane_permute_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [199:0] in_data = '0;
  logic [4:0]   in_rounds = '0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b0;
  int           sel = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic         r1_v, r1_ov, r1_b;
  logic [24:0]  r1_d;
  logic         r8_v, r8_ov, r8_b;
  logic [199:0] r8_d;
  logic         r4_v, r4_ov, r4_b;
  logic [99:0]  r4_d;

  lane_permute_engine #(.W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(r1_v),
    .in_data(in_data[24:0]), .in_rounds(in_rounds), .in_mode(in_mode),
    .out_valid(r1_ov), .out_ready(out_ready && sel == 0), .out_data(r1_d), .busy(r1_b)
  );

  lane_permute_engine #(.W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(r8_v),
    .in_data(in_data), .in_rounds(in_rounds), .in_mode(in_mode),
    .out_valid(r8_ov), .out_ready(out_ready && sel == 1), .out_data(r8_d), .busy(r8_b)
  );

  lane_permute_engine #(.W(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(r4_v),
    .in_data(in_data[99:0]), .in_rounds(in_rounds), .in_mode(in_mode),
    .out_valid(r4_ov), .out_ready(out_ready && sel == 2), .out_data(r4_d), .busy(r4_b)
  );

  logic         obs_in_ready, obs_valid, obs_busy;
  logic [199:0] obs_data;

  always_comb begin
    obs_in_ready = r1_v;
    obs_valid    = r1_ov;
    obs_busy     = r1_b;
    obs_data     = {175'b0, r1_d};
    if (sel == 1) begin
      obs_in_ready = r8_v;
      obs_valid    = r8_ov;
      obs_busy     = r8_b;
      obs_data     = r8_d;
    end else if (sel == 2) begin
      obs_in_ready = r4_v;
      obs_valid    = r4_ov;
      obs_busy     = r4_b;
      obs_data     = {100'b0, r4_d};
    end
  end

  // Offer one job, count cycles (accept cycle included) until out_valid, then drain.
  task automatic run_job(input logic [199:0] d, input logic [4:0] r, input logic m,
                         output logic [199:0] res, output int lat);
    in_data   = d;
    in_rounds = r;
    in_mode   = m;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!obs_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = obs_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", s, obs_in_ready); end
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, obs_valid); end
      checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, obs_busy); end
      checks++; if (obs_data !== 200'b0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", s, obs_data); end
    end
  endtask

  task automatic test_forward_w1();
    logic [199:0] d, res, exp;
    int lat;
    sel = 0;
    d = '0; d[0] = 1'b1;
    // (0,0)->(2,0)=lane 10 ->(3,2)=lane 17 ->(0,3)=lane 3
    run_job(d, 5'd1, 1'b0, res, lat);
    exp = '0; exp[10] = 1'b1;
    checks++; if (res !== exp) begin errors++; $display("FAIL fwd1_data: got %h want %h", res, exp); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL fwd1_latency: got %0d want 2", lat); end
    run_job(d, 5'd2, 1'b0, res, lat);
    exp = '0; exp[17] = 1'b1;
    checks++; if (res !== exp) begin errors++; $display("FAIL fwd2_data: got %h want %h", res, exp); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL fwd2_latency: got %0d want 3", lat); end
    run_job(d, 5'd3, 1'b0, res, lat);
    exp = '0; exp[3] = 1'b1;
    checks++; if (res !== exp) begin errors++; $display("FAIL fwd3_data: got %h want %h", res, exp); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fwd3_latency: got %0d want 4", lat); end
  endtask

  task automatic test_inverse_w8();
    logic [199:0] d, orig, mid, res, exp;
    logic [223:0] rnd;
    int lat;
    sel = 1;
    // One inverse round pulls lane 10 (=F(0,0)) back to lane 0.
    d = '0; d[80 +: 8] = 8'hA5;
    run_job(d, 5'd1, 1'b1, res, lat);
    exp = '0; exp[0 +: 8] = 8'hA5;
    checks++; if (res !== exp) begin errors++; $display("FAIL inv1_data: got %h want %h", res, exp); end
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    orig = rnd[199:0];
    run_job(orig, 5'd5, 1'b0, mid, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL fwd5_latency: got %0d want 6", lat); end
    run_job(mid, 5'd5, 1'b1, res, lat);
    checks++; if (res !== orig) begin errors++; $display("FAIL inv_roundtrip: got %h want %h", res, orig); end
  endtask

  task automatic test_zero_clamp_w4();
    logic [199:0] d, res;
    logic [127:0] rnd;
    int lat;
    sel = 2;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    d = {100'b0, rnd[99:0]};
    run_job(d, 5'd0, 1'b0, res, lat);
    checks++; if (res !== d) begin errors++; $display("FAIL zero_rounds_data: got %h want %h", res, d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_rounds_latency: got %0d want 1", lat); end
    // The forward map has order 24 (one 24-cycle plus fixed lane (2,2)).
    run_job(d, 5'd24, 1'b0, res, lat);
    checks++; if (res !== d) begin errors++; $display("FAIL r24_data: got %h want %h", res, d); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL r24_latency: got %0d want 25", lat); end
    run_job(d, 5'd31, 1'b0, res, lat);
    checks++; if (res !== d) begin errors++; $display("FAIL clamp31_data: got %h want %h", res, d); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL clamp31_latency: got %0d want 25", lat); end
  endtask

  task automatic test_backpressure();
    logic [199:0] d, exp;
    int wait_cyc;
    sel = 1;
    d = '0; d[0 +: 8] = 8'h3C;
    exp = '0; exp[17*8 +: 8] = 8'h3C;
    in_data = d; in_rounds = 5'd2; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!obs_valid && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    checks++; if (obs_data !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", obs_data, exp); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = ~d;
      @(posedge clk); #1;
      checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, obs_valid); end
      checks++; if (obs_data !== exp) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data, exp); end
      checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, obs_in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b want 0", obs_valid); end
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_in_ready: got %b want 1", obs_in_ready); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL bp_drain_busy: got %b want 0", obs_busy); end
    @(posedge clk); #1;
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_stays: got %b want 0", obs_valid); end
  endtask

  task automatic test_mid_reset();
    logic [199:0] d, res, exp;
    int lat;
    sel = 1;
    d = '0; d[0 +: 8] = 8'hFF;
    in_data = d; in_rounds = 5'd10; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;          // accepted; now in RUN cycle 1
    in_valid = 1'b0;
    @(posedge clk); #1;          // RUN cycle 2
    @(posedge clk); #1;          // RUN cycle 3
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b want 1", obs_in_ready); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b want 0", obs_valid); end
    checks++; if (obs_data !== 200'b0) begin errors++; $display("FAIL mrst_out_data: got %h want 0", obs_data); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", obs_busy); end
    d = '0; d[0 +: 8] = 8'h5A;
    run_job(d, 5'd2, 1'b0, res, lat);
    exp = '0; exp[17*8 +: 8] = 8'h5A;
    checks++; if (res !== exp) begin errors++; $display("FAIL mrst_fresh_data: got %h want %h", res, exp); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL mrst_fresh_latency: got %0d want 3", lat); end
  endtask

  initial begin
    test_reset();
    test_forward_w1();
    test_inverse_w8();
    test_zero_clamp_w4();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
